// File: rtl/idct_pkg.sv
// Shared constants and helpers for the IDCT multiply-accumulate lane.
// Holds the HEVC coefficient magnitudes, sign-magnitude pack/unpack helpers
// and the accumulator width rule.
package idct_pkg;

  // HEVC inverse-transform coefficient magnitudes
  localparam int unsigned CoefA = 64;
  localparam int unsigned CoefB = 83;
  localparam int unsigned CoefC = 36;
  localparam int unsigned CoefD = 89;
  localparam int unsigned CoefE = 75;
  localparam int unsigned CoefF = 50;
  localparam int unsigned CoefG = 18;

  // Accumulator width: a full product plus one bit per doubling of the tap count
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Build a coef_w-bit sign-magnitude word, LSB-aligned in 32 bits
  function automatic logic [31:0] sm_pack(input logic neg, input int unsigned mag,
                                          input int unsigned coef_w);
    logic [31:0] w;
    w = mag & ((32'd1 << (coef_w - 1)) - 32'd1);
    w[coef_w-1] = neg;
    return w;
  endfunction

  // Signed value of a coef_w-bit sign-magnitude word
  function automatic int sm_value(input logic [31:0] c, input int unsigned coef_w);
    int mag;
    mag = int'(c & ((32'd1 << (coef_w - 1)) - 32'd1));
    return c[coef_w-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/idct_smul.sv
// Two-stage sign-magnitude multiplier: S1 captures the accepted pair, S2 holds
// the signed product. Both stages freeze while i_en is low; flush empties them.
module idct_smul
  import idct_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_flush,
  input  logic                             i_en,
  input  logic                             i_valid,
  input  logic [DATA_W-1:0]                i_data,
  input  logic [COEF_W-1:0]                i_coef,
  input  logic                             i_last,
  output logic                             o_valid,
  output logic signed [DATA_W+COEF_W-1:0]  o_prod,
  output logic                             o_last
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic                     r_s1_valid;
  logic [DATA_W-1:0]        r_s1_data;
  logic [COEF_W-1:0]        r_s1_coef;
  logic                     r_s1_last;
  logic                     r_s2_valid;
  logic signed [PROD_W-1:0] r_s2_prod;
  logic                     r_s2_last;

  logic [COEF_W-2:0]        w_mag;
  logic signed [PROD_W-1:0] w_prod_mag;
  logic signed [PROD_W-1:0] w_prod;

  assign w_mag      = r_s1_coef[COEF_W-2:0];
  // Magnitude is zero-extended so the multiply stays signed
  assign w_prod_mag = $signed(r_s1_data) * $signed({1'b0, w_mag});
  assign w_prod     = r_s1_coef[COEF_W-1] ? -w_prod_mag : w_prod_mag;

  // S1: capture the accepted sample/coefficient pair
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_coef  <= '0;
      r_s1_last  <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (i_en) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_data <= i_data;
        r_s1_coef <= i_coef;
        r_s1_last <= i_last;
      end
    end
  end

  // S2: register the signed product
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_last  <= 1'b0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (i_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_prod <= w_prod;
        r_s2_last <= r_s1_last;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_prod  = r_s2_prod;
  assign o_last  = r_s2_last;

endmodule

// File: rtl/idct_mac_ppl.sv
// Pipelined IDCT multiply-accumulate lane: accumulates NTAPS sign-magnitude
// products, rounds/shifts the sum and emits one word per NTAPS pairs.
// Build option: define IDCT_SAT_EN to clip results to OUT_W and flag out_sat;
// otherwise results wrap and out_sat is constant 0.
module idct_mac_ppl
  import idct_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned NTAPS  = 8,
  parameter int unsigned SHIFT  = 7,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [COEF_W-1:0]        in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat,
  output logic [$clog2(NTAPS)-1:0] tap_idx
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int unsigned TAP_W  = $clog2(NTAPS);
  // Wide enough for the rounding carry and for clip compares against OUT_W bounds
  localparam int unsigned RW     = ACC_W + OUT_W + 1;
  localparam logic [TAP_W-1:0] LastTap = TAP_W'(NTAPS - 1);

  logic                     r_out_valid;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_sat;
  logic [TAP_W-1:0]         r_tap_idx;
  logic signed [ACC_W-1:0]  r_acc;

  logic                     w_stall;
  logic                     w_accept;
  logic                     w_s2_valid;
  logic signed [PROD_W-1:0] w_s2_prod;
  logic                     w_s2_last;
  logic                     w_s3_en;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [RW-1:0]     w_sum_ext;
  logic signed [RW-1:0]     w_r;
  logic [OUT_W-1:0]         w_out;
  logic                     w_sat;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~flush;
  assign w_accept = in_valid & in_ready;

  idct_smul #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_smul (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_en    (~w_stall),
    .i_valid (w_accept),
    .i_data  (in_data),
    .i_coef  (in_coef),
    .i_last  (r_tap_idx == LastTap),
    .o_valid (w_s2_valid),
    .o_prod  (w_s2_prod),
    .o_last  (w_s2_last)
  );

  assign w_s3_en    = w_s2_valid & ~w_stall & ~flush;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_s2_prod[PROD_W-1]}}, w_s2_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_sum_ext  = {{(RW - ACC_W){w_sum[ACC_W-1]}}, w_sum};

  if (SHIFT > 0) begin : g_round
    // Add half an LSB, then arithmetic shift: ties go toward +inf
    assign w_r = (w_sum_ext + (RW'(1) << (SHIFT - 1))) >>> SHIFT;
  end else begin : g_no_round
    assign w_r = w_sum_ext;
  end

`ifdef IDCT_SAT_EN
  localparam logic signed [RW-1:0] MaxV = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] MinV = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  logic w_hi;
  logic w_lo;
  assign w_hi  = w_r > MaxV;
  assign w_lo  = w_r < MinV;
  assign w_out = w_hi ? MaxV[OUT_W-1:0] : (w_lo ? MinV[OUT_W-1:0] : w_r[OUT_W-1:0]);
  assign w_sat = w_hi | w_lo;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_r[RW-1:OUT_W];
  assign w_out       = w_r[OUT_W-1:0];
  assign w_sat       = 1'b0;
`endif

  // Tap counter: advances per accepted pair, wraps after the last tap
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_tap_idx <= '0;
    end else if (w_accept) begin
      r_tap_idx <= (r_tap_idx == LastTap) ? '0 : r_tap_idx + 1'b1;
    end
  end

  // S3 accumulator: clears after the last product so tap 0 loads the product
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_acc <= '0;
    end else if (w_s3_en) begin
      r_acc <= w_s2_last ? '0 : w_sum;
    end
  end

  // Output register: written on a completed word, drained by out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_s3_en && w_s2_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out;
      r_out_sat   <= w_sat;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign tap_idx   = r_tap_idx;

endmodule

// File: tb/tb_idct_mac_ppl.sv
// Self-checking bench for idct_mac_ppl: directed scenarios plus randomized
// traffic against a word-level reference model (sum of products, round, wrap/clip).
module tb_idct_mac_ppl;
  import idct_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data, in_coef;

  // Default lane
  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [15:0] a_out_data;
  logic [2:0]  a_tap_idx;
  // NTAPS=4 lane
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [15:0] b_out_data;
  logic [1:0]  b_tap_idx;
  // OUT_W=8, SHIFT=0 lane
  logic        c_in_ready, c_out_valid, c_out_sat;
  logic [7:0]  c_out_data;
  logic [2:0]  c_tap_idx;

  idct_mac_ppl u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_coef(in_coef), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat), .tap_idx(a_tap_idx)
  );

  idct_mac_ppl #(.NTAPS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_coef(in_coef), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat), .tap_idx(b_tap_idx)
  );

  idct_mac_ppl #(.OUT_W(8), .SHIFT(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_coef(in_coef), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_sat(c_out_sat), .tap_idx(c_tap_idx)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state for lane A
  longint exp_q[$];
  bit     exp_sat_q[$];
  longint part_sum = 0;
  int     part_n = 0;
  bit     acc;
  logic [2:0] tap_hold;
  int     stalls;

  int unsigned mags[8] = '{0, CoefA, CoefB, CoefC, CoefD, CoefE, CoefF, CoefG};

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_round(input longint sum, input int shift);
    return (shift > 0) ? ((sum + (longint'(1) << (shift - 1))) >>> shift) : sum;
  endfunction

  function automatic longint ref_out(input longint r, input int outw, output bit sat);
    longint hi, lo, m;
    hi = (longint'(1) << (outw - 1)) - 1;
    lo = -(longint'(1) << (outw - 1));
`ifdef IDCT_SAT_EN
    sat = (r > hi) || (r < lo);
    return (r > hi) ? hi : ((r < lo) ? lo : r);
`else
    sat = 1'b0;
    m = r & ((longint'(1) << outw) - 1);
    if (m > hi) m -= (longint'(1) << outw);
    return m;
`endif
  endfunction

  task automatic new_pair();
    in_data = 8'($urandom_range(0, 255));
    in_coef = 8'(sm_pack(1'($urandom_range(0, 1)), mags[$urandom_range(0, 7)], 8));
  endtask

  // One clock: check handshake and outputs of lane A against the model, then advance
  task automatic step(output bit accepted);
    bit     exp_rdy;
    bit     s;
    longint e;
    #1;
    exp_rdy = !(a_out_valid && !out_ready) && !flush;
    chk("in_ready", a_in_ready, exp_rdy);
    accepted = rst_n && in_valid && exp_rdy;
    if (!rst_n) begin
      part_sum = 0;
      part_n   = 0;
      exp_q.delete();
      exp_sat_q.delete();
    end else begin
      if (a_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", a_out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          s = exp_sat_q.pop_front();
          chk("out_data", $signed(a_out_data), e);
          chk("out_sat", a_out_sat, s);
        end
      end
      if (flush) begin
        part_sum = 0;
        part_n   = 0;
      end else if (accepted) begin
        part_sum += longint'($signed(in_data)) * sm_value(32'(in_coef), 8);
        part_n++;
        if (part_n == 8) begin
          e = ref_out(ref_round(part_sum, 7), 16, s);
          exp_q.push_back(e);
          exp_sat_q.push_back(s);
          part_sum = 0;
          part_n   = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step(acc);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_coef = '0;
    @(negedge clk);
    step(acc);
    step(acc);
    rst_n = 1'b1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", $signed(a_out_data), 0);
    chk("rst_out_sat", a_out_sat, 0);
    chk("rst_tap_idx", a_tap_idx, 0);
    chk("rst_in_ready", a_in_ready, 1);

    // Scenario 1: eight (3,+64) pairs, latency and value
    in_valid = 1'b1; in_data = 8'd3; in_coef = 8'(sm_pack(1'b0, 64, 8));
    for (int i = 0; i < 8; i++) step(acc);
    in_valid = 1'b0;
    chk("lat_k0", a_out_valid, 0);
    step(acc);
    chk("lat_k1", a_out_valid, 0);
    step(acc);
    chk("lat_k2", a_out_valid, 1);
    chk("s1_data", $signed(a_out_data), 12);
    step(acc);

    // Scenario 2: NTAPS=4 lane, mixed signs, tap index walk
    do_reset();
    in_valid = 1'b1; in_data = 8'd3;
    for (int i = 0; i < 4; i++) begin
      chk("b_tap", b_tap_idx, i);
      case (i)
        0:       in_coef = 8'(sm_pack(1'b0, 64, 8));
        1:       in_coef = 8'(sm_pack(1'b0, 83, 8));
        2:       in_coef = 8'(sm_pack(1'b1, 89, 8));
        default: in_coef = 8'(sm_pack(1'b0, 75, 8));
      endcase
      step(acc);
    end
    in_valid = 1'b0;
    chk("b_tap_wrap", b_tap_idx, 0);
    step(acc);
    step(acc);
    chk("b_out_valid", b_out_valid, 1);
    chk("b_out_data", $signed(b_out_data), 3);

    // Scenario 3: OUT_W=8, SHIFT=0 lane, out-of-range sum
    do_reset();
    in_valid = 1'b1; in_data = 8'd127; in_coef = 8'(sm_pack(1'b0, 89, 8));
    for (int i = 0; i < 8; i++) step(acc);
    in_valid = 1'b0;
    step(acc);
    step(acc);
    chk("c_out_valid", c_out_valid, 1);
`ifdef IDCT_SAT_EN
    chk("c_out_data", $signed(c_out_data), 127);
    chk("c_out_sat", c_out_sat, 1);
`else
    chk("c_out_data", $signed(c_out_data), 56);
    chk("c_out_sat", c_out_sat, 0);
`endif
    step(acc);

    // Scenario 4: continuous random input with a 5-cycle output stall
    do_reset();
    in_valid = 1'b1;
    new_pair();
    stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (a_out_valid && stalls < 5) begin
        if (stalls == 0) tap_hold = a_tap_idx;
        else chk("stall_tap", a_tap_idx, tap_hold);
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      step(acc);
      if (acc) new_pair();
    end

    // Randomized traffic: gaps on input, back-pressure on output
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
      if (acc) new_pair();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(acc);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", a_out_valid, 0);

    // Scenario 5: flush at tap 5, then eight (-2,+36) pairs
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      new_pair();
      step(acc);
    end
    chk("pre_flush_tap", a_tap_idx, 5);
    flush = 1'b1;
    new_pair();
    step(acc);
    flush = 1'b0;
    chk("flush_tap", a_tap_idx, 0);
    in_data = 8'hFE; in_coef = 8'(sm_pack(1'b0, 36, 8));
    for (int i = 0; i < 8; i++) step(acc);
    in_valid = 1'b0;
    step(acc);
    step(acc);
    chk("s5_valid", a_out_valid, 1);
    chk("s5_data", $signed(a_out_data), -4);
    // A completed word survives a flush
    out_ready = 1'b0; flush = 1'b1;
    step(acc);
    flush = 1'b0;
    chk("flush_keep_valid", a_out_valid, 1);
    chk("flush_keep_data", $signed(a_out_data), -4);
    out_ready = 1'b1;
    step(acc);

    // Scenario 6: reset mid-word at tap 3, then a fresh word
    in_valid = 1'b1; in_data = 8'd3; in_coef = 8'(sm_pack(1'b0, 64, 8));
    for (int i = 0; i < 3; i++) step(acc);
    chk("pre_rst_tap", a_tap_idx, 3);
    do_reset();
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_data", $signed(a_out_data), 0);
    chk("mid_rst_sat", a_out_sat, 0);
    chk("mid_rst_tap", a_tap_idx, 0);
    chk("mid_rst_ready", a_in_ready, 1);
    in_valid = 1'b1; in_data = 8'd3; in_coef = 8'(sm_pack(1'b0, 64, 8));
    for (int i = 0; i < 8; i++) step(acc);
    in_valid = 1'b0;
    step(acc);
    step(acc);
    chk("s6_valid", a_out_valid, 1);
    chk("s6_data", $signed(a_out_data), 12);
    step(acc);
    chk("s6_drained", a_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
